// File: rtl/ucie_clk_pattern_gen.sv
// ucie_clk_pattern_gen
//   Forwarded-clock pattern generator for the UCIe mainband clock lanes.
//   It sits between the MB clock TX FSM and the lane drivers. The block
//   produces a single toggle bit (tgl) and fans it out to every clock lane
//   through a per-lane enable mask and a per-lane phase-invert mask.
//
//   Modes (i_mode):
//     00 off        : all lanes low, tgl held at 0
//     01 strobe     : tgl toggles on every edge with i_valid high, else 0
//     10 continuous : tgl toggles on every edge
//     11 repair     : ITERATIONS groups of {BURST_CYCLES toggles,
//                     GAP_CYCLES forced-low}; o_done pulses at the end
//
// Ports
//   i_clk       single clock
//   i_rst       synchronous active-high reset
//   i_mode      operating mode (see above)
//   i_valid     strobe-mode gate
//   i_start     repair start request (only taken in IDLE with mode 11)
//   i_abort     terminates a repair run; wins over a same-cycle start
//   i_lane_en   per-lane output enable
//   i_invert    per-lane phase inversion (only while the lane is active)
//   o_lanes     registered lane outputs
//   o_det_en    registered per-lane detector enables
//   o_busy      repair run in progress
//   o_done      one-cycle repair completion pulse
//   o_iter_cnt  completed repair groups in the current or last run

module ucie_clk_pattern_gen #(
    parameter int unsigned NUM_LANES    = 3,
    parameter int unsigned BURST_CYCLES = 32,
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned ITERATIONS   = 128,
    parameter int unsigned ITER_W       = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [1:0]           i_mode,
    input  logic                 i_valid,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [NUM_LANES-1:0] i_lane_en,
    input  logic [NUM_LANES-1:0] i_invert,
    output logic [NUM_LANES-1:0] o_lanes,
    output logic [NUM_LANES-1:0] o_det_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ITER_W-1:0]    o_iter_cnt
);

    // One shared phase counter serves both BURST and GAP, so it is sized
    // for the longer of the two.
    localparam int unsigned CntMax = (BURST_CYCLES > GAP_CYCLES) ? BURST_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0]   BurstLast = CntW'(BURST_CYCLES - 1);
    localparam logic [CntW-1:0]   GapLast   = CntW'(GAP_CYCLES - 1);
    localparam logic [ITER_W-1:0] IterLimit = ITER_W'(ITERATIONS);

    localparam logic [1:0] ModeOff    = 2'b00;
    localparam logic [1:0] ModeStrobe = 2'b01;
    localparam logic [1:0] ModeCont   = 2'b10;
    localparam logic [1:0] ModeRepair = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StGap,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [ITER_W-1:0]      iter_q, iter_d;
    logic                   tgl_q, tgl_d;
    logic [NUM_LANES-1:0]   lanes_q, lanes_d;
    logic [NUM_LANES-1:0]   det_q, det_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Classification of the cycle that the next registered outputs belong to.
    logic                   active;
    logic                   in_gap;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iter_d  = iter_q;
        tgl_d   = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        active  = 1'b0;
        in_gap  = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                unique case (i_mode)
                    ModeOff: begin
                        tgl_d = 1'b0;
                    end
                    ModeStrobe: begin
                        if (i_valid) begin
                            tgl_d  = ~tgl_q;
                            active = 1'b1;
                        end
                    end
                    ModeCont: begin
                        tgl_d  = ~tgl_q;
                        active = 1'b1;
                    end
                    ModeRepair: begin
                        // The start edge already presents the first burst
                        // cycle (tgl=1); abort on the same edge suppresses it.
                        if (i_start && !i_abort) begin
                            state_d = StBurst;
                            cnt_d   = '0;
                            iter_d  = '0;
                            busy_d  = 1'b1;
                            tgl_d   = 1'b1;
                            active  = 1'b1;
                        end
                    end
                    default: begin
                        tgl_d = 1'b0;
                    end
                endcase
            end

            // cnt_q is the index of the burst/gap cycle currently on the lanes.
            StBurst: begin
                if (i_abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == BurstLast) begin
                    state_d = StGap;
                    cnt_d   = '0;
                    in_gap  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    tgl_d  = ~tgl_q;
                    active = 1'b1;
                end
            end

            StGap: begin
                if (i_abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == GapLast) begin
                    iter_d = iter_q + 1'b1;
                    cnt_d  = '0;
                    if (iter_d == IterLimit) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StBurst;
                        tgl_d   = 1'b1;
                        active  = 1'b1;
                    end
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    in_gap = 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        // Inactive lanes are forced low, so the invert mask cannot leak out.
        lanes_d = active ? (i_lane_en & ({NUM_LANES{tgl_d}} ^ i_invert)) : '0;
        det_d   = (active || in_gap) ? i_lane_en : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            iter_q  <= '0;
            tgl_q   <= 1'b0;
            lanes_q <= '0;
            det_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
            tgl_q   <= tgl_d;
            lanes_q <= lanes_d;
            det_q   <= det_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_lanes    = lanes_q;
    assign o_det_en   = det_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_iter_cnt = iter_q;

endmodule

// File: doc/ucie_clk_pattern_gen.md
Name: ucie_clk_pattern_gen

Overview:
- Parametrised single-clock forwarded-clock pattern generator for the mainband clock lanes (CKP, CKN, Track and optional extras).
- Supports four modes: off, strobe (gated by valid), continuous, and repair/training. Repair emits N groups of {burst toggles, idle gap} and signals completion.
- Adds per-lane enable and phase-invert masks, start/abort handshake, iteration readback and per-lane detector enables. Sits between the MB clock TX FSM and the lane drivers.

Parameters:
- NUM_LANES, 3, number of clock lanes (bit 0 = CKP, bit 1 = CKN, bit 2 = Track).
- BURST_CYCLES, 32, toggling cycles per repair group. Must be even and >= 2.
- GAP_CYCLES, 16, forced-low cycles per repair group. Must be >= 1.
- ITERATIONS, 128, repair groups per run. Must be >= 1.
- ITER_W, 8, width of o_iter_cnt. Must satisfy 2^ITER_W > ITERATIONS.

Ports:
- i_clk  in  1  single clock.
- i_rst  in  1  synchronous, active-high reset.
- i_mode  in  2  00 off, 01 strobe, 10 continuous, 11 repair.
- i_valid  in  1  strobe-mode gate.
- i_start  in  1  repair start request, sampled only in IDLE with i_mode==11.
- i_abort  in  1  terminates a repair run.
- i_lane_en  in  NUM_LANES  per-lane output enable.
- i_invert  in  NUM_LANES  per-lane phase inversion, applied only while a lane is active.
- o_lanes  out  NUM_LANES  registered lane outputs.
- o_det_en  out  NUM_LANES  registered detector enables.
- o_busy  out  1  repair run in progress.
- o_done  out  1  one-cycle completion pulse.
- o_iter_cnt  out  ITER_W  completed repair groups in the current or last run.

Behaviour:
- Reset (sync, i_rst==1 at an edge, overrides everything):
  - state=IDLE; toggle reg, counters, o_lanes, o_det_en, o_busy, o_done and o_iter_cnt all 0.
  - Reset mid-run aborts silently: no o_done pulse.
- Lane output rule (registered):
  - Active lane: o_lanes[i] = i_lane_en[i] & (tgl ^ i_invert[i]).
  - Inactive lane: o_lanes[i] = 0, irrespective of i_invert. Inactive means mode off, strobe with valid low, or repair gap/IDLE.
- o_det_en[i] = i_lane_en[i] while the lane is active or in a repair GAP. Same registered timing as o_lanes.
- Mode 00: all outputs low; tgl held at 0.
- Mode 01, strobe:
  - While i_valid==1, tgl toggles every cycle. The first edge with valid high gives tgl=1, so non-inverted lanes go high the cycle after valid rises.
  - Edge with i_valid==0: tgl<=0 and outputs go low the next cycle.
- Mode 10, continuous: tgl toggles every cycle regardless of i_valid.
- Mode 11, repair FSM with states IDLE, BURST, GAP, DONE:
  - IDLE -> BURST when i_start==1. Clear burst_cnt and o_iter_cnt; o_busy<=1.
    - Taking the sampling edge as E0, the outputs after edges E0..E(B-1) are 1,0,1,0,...,0 (B = BURST_CYCLES).
  - BURST: tgl toggles each cycle. After B cycles -> GAP.
  - GAP: tgl forced 0, outputs low. After GAP_CYCLES cycles, o_iter_cnt increments.
    - If o_iter_cnt now equals ITERATIONS -> DONE; otherwise -> BURST.
    - Group period P = B + GAP_CYCLES.
  - DONE: o_done=1 and o_busy=0 after edge E(ITERATIONS*P), for exactly 1 cycle; then -> IDLE. o_iter_cnt holds ITERATIONS until the next start.
- i_mode is latched at start: mode changes during a run are ignored until IDLE. In IDLE with mode 11 and no start, outputs are low.
- i_start while busy is ignored. i_start while i_mode!=11 is ignored.
- i_abort in BURST or GAP:
  - Next state IDLE, outputs low, o_busy<=0, no o_done, o_iter_cnt holds its partial count.
  - If i_abort and i_start arrive in the same IDLE cycle, abort wins and no run starts.
- Counters are sized by $clog2 of their limits and must not wrap within a run.

Test Plan:
- Reset check: assert i_rst for 3 cycles during continuous mode -> all outputs 0 on the first cycle after reset; toggling resumes the cycle after release.
- Repair, defaults: lane_en=111, invert=010, start pulse.
  - Lane0 shows 16 highs in 32 cycles then 16 lows, repeated 128 times.
  - Lane1 is the complement of lane0 during BURST and 0 during GAP.
  - o_done pulses once at cycle 6144 after start; o_iter_cnt=128.
- Strobe: mode 01, valid high for 6 cycles -> lanes toggle 1,0,1,0,1,0 and then go low; o_det_en is high for exactly those 6 cycles.
- Abort: abort at cycle 100 of repair -> outputs low next cycle, o_busy=0, no o_done, o_iter_cnt=2.
- Param override: BURST_CYCLES=4, GAP_CYCLES=2, ITERATIONS=3 -> pattern 1010 00 repeated 3 times; done after edge 18.
- Ignored inputs:
  - Start during a run has no effect.
  - A mode change to 10 mid-run does not alter the pattern.
  - lane_en=001 -> only lane0 toggles; other lanes and their det_en stay 0.
